// File: rtl/pattern_tx_if.sv
// Word-in / serial-out bundle between a valid/ready producer and the frame transmitter.
interface pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             data_out;
    logic             tx_active;
    logic             done;

    modport master (
        output in_data, in_valid,
        input  in_ready, data_out, tx_active, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data_out, tx_active, done
    );
endinterface

// File: rtl/pattern_tx.sv
// Serialises each accepted word as preamble 0,1,0 then WIDTH bits MSB first; first bit 1 cycle after accept.
// Backpressure: in_ready is high only in IDLE, so a producer waits out preamble, data and the idle-high gap.
module pattern_tx #(
    parameter int WIDTH    = 8,
    parameter int IDLE_MIN = 2
) (
    input  logic         clk,
    input  logic         rstn,
    pattern_tx_if.slave  tx
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH);
    localparam logic [3:0]     GAP_LAST = 4'(IDLE_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             data_out_q, data_out_d;
    logic             tx_active_q, tx_active_d;
    logic             done_q, done_d;
    logic             accept;

    // Ready is gated by reset so a producer never sees an accept while rstn is low.
    assign tx.in_ready  = (state_q == IDLE) && rstn;
    assign accept       = tx.in_valid && tx.in_ready;
    assign tx.data_out  = data_out_q;
    assign tx.tx_active = tx_active_q;
    assign tx.done      = done_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= 1'b1;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
        end
    end

    // Outputs are computed for the next state so they appear registered in the cycle that state occupies.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shift_d     = shift_q;
        data_out_d  = 1'b1;
        tx_active_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = PRE;
                    shift_d     = tx.in_data;
                    pre_cnt_d   = 2'd0;
                    data_out_d  = 1'b0;
                    tx_active_d = 1'b1;
                end
            end
            PRE: begin
                tx_active_d = 1'b1;
                if (pre_cnt_q == 2'd2) begin
                    state_d    = DATA;
                    pre_cnt_d  = 2'd0;
                    data_out_d = shift_q[WIDTH-1];
                    shift_d    = shift_q << 1;
                    bit_cnt_d  = CW'(1);
                end else begin
                    pre_cnt_d  = pre_cnt_q + 2'd1;
                    data_out_d = (pre_cnt_q == 2'd0);
                end
            end
            DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = GAP;
                    bit_cnt_d = '0;
                    gap_cnt_d = 4'd1;
                    done_d    = 1'b1;
                end else begin
                    tx_active_d = 1'b1;
                    data_out_d  = shift_q[WIDTH-1];
                    shift_d     = shift_q << 1;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                pre_cnt_d = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end
endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial frame transmitter that drives the single-bit stream consumed by the 010 pattern detector. Each parallel word accepted on a valid/ready handshake goes out as a 3-bit preamble 0,1,0 followed by WIDTH data bits, MSB first. Between frames the line idles high for a guaranteed minimum gap. The block sits at the sending end of the serial link, fed by any producer with a valid/ready port.

## Interface
- WIDTH, 8: data bits per frame; legal range 1..32.
- IDLE_MIN, 2: number of GAP cycles after each frame; legal range 1..15.

- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  word to transmit; sampled only on accept.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word; combinational from state.
- data_out  output  1  serial line, registered; idle level is 1.
- tx_active  output  1  registered; high while a preamble or data bit is on data_out.
- done  output  1  registered single-cycle pulse marking frame completion.

## Operation
- States:
  - IDLE: data_out=1, in_ready=1.
  - PRE: 3 cycles, bits 0,1,0.
  - DATA: WIDTH cycles.
  - GAP: IDLE_MIN cycles, data_out=1.
- Accept condition: in_valid && in_ready at a rising edge. At accept, in_data is copied into an internal shift register. Later changes on in_data have no effect on the frame in flight.
- IDLE -> PRE on accept. Otherwise stay in IDLE.
- PRE -> DATA after the third preamble bit. A 2-bit counter tracks preamble position.
- DATA -> GAP after bit 0 has been driven. The shift register shifts left each DATA cycle, and data_out takes the MSB. A bit counter of width clog2(WIDTH+1) tracks position.
- GAP -> IDLE after IDLE_MIN cycles. A gap counter of 4 bits tracks them.
- in_ready is 0 in PRE, DATA, GAP, and while rstn=0.
- done is 1 for exactly the first GAP cycle. It is 0 at all other times.
- Reset: rstn=0 sampled at an edge forces the following values from the next cycle on:
  - state=IDLE, data_out=1, tx_active=0, done=0.
  - All counters and the shift register cleared.
- Reset mid-frame: the frame is abandoned with no done pulse. The line returns high immediately, with no gap.
- Unreachable state encodings recover to IDLE with data_out=1.

## Timing
- Cycle k is the cycle whose closing edge performs the accept.
- Preamble 0,1,0 on data_out in cycles k+1, k+2, k+3.
- Data bit WIDTH-1 down to bit 0 in cycles k+4 through k+3+WIDTH.
- tx_active=1 in cycles k+1 through k+3+WIDTH; 0 otherwise.
- done=1 in cycle k+4+WIDTH.
- GAP occupies cycles k+4+WIDTH through k+3+WIDTH+IDLE_MIN.
- in_ready=1 again in cycle k+4+WIDTH+IDLE_MIN.
- Frame period with in_valid held high: WIDTH+IDLE_MIN+4 cycles.
- Minimum high-level run between frames: IDLE_MIN+1 cycles.
- Latency from accept to first preamble bit: 1 cycle.
- While rstn=0 at every edge, all outputs stay at reset values and in_ready=0.
- First accept is possible at the edge that ends the first cycle with rstn=1 after reset.

## Test plan
- Reset: hold rstn=0 for 3 cycles with in_valid=1.
  - Required: data_out=1, tx_active=0, done=0, in_ready=0 throughout.
  - Required: in_ready=1 in the first cycle after release.
- Single frame: WIDTH=8, IDLE_MIN=2, in_data=0xA5 accepted in cycle k.
  - Required data_out from k+1: 0,1,0,1,0,1,0,0,1,0,1, then 1s.
  - Required: done only in k+12; in_ready=1 in k+14.
- Back-to-back: in_valid held high with words 0xFF then 0x00.
  - Required: second accept in k+14; second preamble starts in k+15.
  - Required: second frame bits 0,1,0,0,0,0,0,0,0,0,0; exactly one done per frame.
- Data stability: change in_data from 0x3C to 0xC3 in cycle k+2.
  - Required: transmitted data bits still 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert rstn=0 for 1 cycle during data bit 4.
  - Required next cycle: data_out=1, tx_active=0, done=0.
  - Required: no done pulse for the abandoned frame; a new accept is possible two cycles later.
- Parameter corner: WIDTH=1, IDLE_MIN=1, in_data=1.
  - Required: data_out 0,1,0,1 in k+1..k+4; done in k+5; in_ready=1 in k+6.
